// File: rtl/z_xfer_seq_pkg.sv
// Shared types and defaults for the Z result register transfer sequencer.
// The state encoding is 3 bits wide and is visible on the interface for debug.
package z_xfer_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_ALU = 3'd1,
    S_CAPTURE  = 3'd2,
    S_OUT_LO   = 3'd3,
    S_OUT_HI   = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam int DEF_ALU_TIMEOUT = 32;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/z_xfer_seq_if.sv
// Bundle between the control unit side (master) and the Z transfer sequencer (slave).
interface z_xfer_seq_if;
  import z_xfer_seq_pkg::*;

  // start is a request level sampled only while the sequencer is idle (busy=0);
  // it is accepted on the rising edge where state is IDLE, start=1 and abort=0.
  // Completion is the single-cycle done pulse; a new start is taken no earlier
  // than the IDLE cycle that follows done.
  logic   start;
  logic   op_wide;
  logic   alu_ready;
  logic   abort;
  logic   ZIn;
  logic   ZLowOut;
  logic   ZHighOut;
  logic   Rin;
  logic   LOin;
  logic   HIin;
  logic   busy;
  logic   done;
  logic   err;
  state_t state;

  modport master (
    output start, op_wide, alu_ready, abort,
    input  ZIn, ZLowOut, ZHighOut, Rin, LOin, HIin, busy, done, err, state
  );

  modport slave (
    input  start, op_wide, alu_ready, abort,
    output ZIn, ZLowOut, ZHighOut, Rin, LOin, HIin, busy, done, err, state
  );

endinterface

// File: rtl/z_timeout_cnt.sv
// Counts cycles spent waiting for the ALU; tc flags the last allowed wait cycle.
module z_timeout_cnt #(
  parameter int CNT_W = 8,
  parameter int TERM  = 31
) (
  input  logic clk,
  input  logic clr,
  input  logic clear,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == CNT_W'(TERM));

endmodule

// File: rtl/z_xfer_seq.sv
// Moore sequencer that captures the ALU result into Z and steers its halves
// onto the bus together with the matching destination load enable.
module z_xfer_seq
  import z_xfer_seq_pkg::*;
#(
  parameter int ALU_TIMEOUT = DEF_ALU_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic          clk,
  input logic          clr,
  z_xfer_seq_if.slave  xf
);

  state_t state, state_nxt;
  logic   wide_q;
  logic   err_q;
  logic   accept;
  logic   err_set;
  logic   tc;

  // Counter only runs while waiting; any other state holds it at zero.
  z_timeout_cnt #(
    .CNT_W (CNT_W),
    .TERM  (ALU_TIMEOUT - 1)
  ) u_timeout_cnt (
    .clk   (clk),
    .clr   (clr),
    .clear (state != S_WAIT_ALU),
    .en    ((state == S_WAIT_ALU) && !xf.alu_ready),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state  <= S_IDLE;
      wide_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wide_q <= xf.op_wide;
        err_q  <= 1'b0;
      end else if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    err_set   = 1'b0;
    case (state)
      S_IDLE: begin
        if (xf.start) begin
          state_nxt = S_WAIT_ALU;
          accept    = 1'b1;
        end
      end
      S_WAIT_ALU: begin
        if (xf.alu_ready) begin
          state_nxt = S_CAPTURE;
        end else if (tc) begin
          state_nxt = S_IDLE;
          err_set   = 1'b1;
        end
      end
      S_CAPTURE: state_nxt = S_OUT_LO;
      S_OUT_LO:  state_nxt = wide_q ? S_OUT_HI : S_DONE;
      S_OUT_HI:  state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    // abort overrides everything, including a start or a timeout in the same cycle
    if (xf.abort) begin
      state_nxt = S_IDLE;
      accept    = 1'b0;
      err_set   = 1'b0;
    end
  end

  always_comb begin
    xf.ZIn      = 1'b0;
    xf.ZLowOut  = 1'b0;
    xf.ZHighOut = 1'b0;
    xf.Rin      = 1'b0;
    xf.LOin     = 1'b0;
    xf.HIin     = 1'b0;
    xf.done     = 1'b0;
    case (state)
      S_CAPTURE: xf.ZIn = 1'b1;
      S_OUT_LO: begin
        xf.ZLowOut = 1'b1;
        xf.LOin    = wide_q;
        xf.Rin     = !wide_q;
      end
      S_OUT_HI: begin
        xf.ZHighOut = 1'b1;
        xf.HIin     = 1'b1;
      end
      S_DONE:  xf.done = 1'b1;
      default: ;
    endcase
  end

  assign xf.busy  = (state != S_IDLE);
  assign xf.err   = err_q;
  assign xf.state = state;

endmodule

// File: tb/tb_z_xfer_seq.sv
// Directed bench for z_xfer_seq: per-cycle expected output vectors
// {busy,done,err,ZIn,ZLowOut,ZHighOut,Rin,LOin,HIin} plus invariant checks.
module tb_z_xfer_seq;
  import z_xfer_seq_pkg::*;

  logic clk;
  logic clr;
  int   checks;
  int   failures;
  int   done_cnt;
  logic [8:0] exp_q[$];

  z_xfer_seq_if xf();

  z_xfer_seq #(
    .ALU_TIMEOUT (4),
    .CNT_W       (8)
  ) dut (
    .clk (clk),
    .clr (clr),
    .xf  (xf)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [8:0] outs();
    return {xf.busy, xf.done, xf.err, xf.ZIn, xf.ZLowOut, xf.ZHighOut,
            xf.Rin, xf.LOin, xf.HIin};
  endfunction

  function automatic logic inv_viol();
    return (xf.ZLowOut & xf.ZHighOut)
         | (xf.ZIn & (xf.ZLowOut | xf.ZHighOut))
         | (xf.Rin & !xf.ZLowOut) | (xf.LOin & !xf.ZLowOut)
         | (xf.HIin & !xf.ZHighOut)
         | ((32'(xf.Rin) + 32'(xf.LOin) + 32'(xf.HIin)) > 1);
  endfunction

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Check outputs of the current cycle, then advance to 1 time unit past the next edge.
  task automatic cyc(input string tag, input logic [8:0] exp);
    chk(tag, 16'(outs()), 16'(exp));
    chk({tag, "_inv"}, 16'(inv_viol()), 16'd0);
    if (xf.done) done_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_q(input string tag);
    while (exp_q.size() > 0) cyc(tag, exp_q.pop_front());
  endtask

  task automatic drive(input logic s, input logic w, input logic r, input logic a);
    xf.start     = s;
    xf.op_wide   = w;
    xf.alu_ready = r;
    xf.abort     = a;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    done_cnt = 0;
    clr      = 1'b0;
    drive(0, 0, 0, 0);
    #12;
    chk("rst_outs", 16'(outs()), 16'd0);
    chk("rst_state", 16'(xf.state), 16'(S_IDLE));
    @(posedge clk);
    #1;
    clr = 1'b1;

    // 1: narrow op, alu_ready held high past WAIT_ALU is ignored
    drive(1, 0, 0, 0); cyc("t1_c0", 9'h000);
    drive(0, 0, 1, 0); cyc("t1_c1", 9'h100);
    cyc("t1_c2", 9'h120);
    cyc("t1_c3", 9'h114);
    drive(0, 0, 0, 0); cyc("t1_c4", 9'h180);

    // 2: wide op, start at cycle 5, ready at 6
    drive(1, 1, 0, 0); cyc("t2_c5", 9'h000);
    drive(0, 0, 1, 0); cyc("t2_c6", 9'h100);
    drive(0, 0, 0, 0); cyc("t2_c7", 9'h120);
    cyc("t2_c8", 9'h112);
    cyc("t2_c9", 9'h109);
    cyc("t2_c10", 9'h180);
    cyc("t2_c11", 9'h000);

    // 3: timeout after 4 wait cycles, then a wide op with two extra waits clears err
    drive(1, 0, 0, 0); cyc("t3_c0", 9'h000);
    drive(0, 0, 0, 0);
    cyc("t3_w1", 9'h100);
    cyc("t3_w2", 9'h100);
    cyc("t3_w3", 9'h100);
    cyc("t3_w4", 9'h100);
    cyc("t3_err", 9'h040);
    drive(1, 1, 0, 0); cyc("t3_err2", 9'h040);
    drive(0, 0, 0, 0); cyc("t3_w0b", 9'h100);
    cyc("t3_w1b", 9'h100);
    drive(0, 0, 1, 0); cyc("t3_w2b", 9'h100);
    drive(0, 0, 0, 0); cyc("t3_zin", 9'h120);
    cyc("t3_lo", 9'h112);
    cyc("t3_hi", 9'h109);
    cyc("t3_done", 9'h180);
    cyc("t3_idle", 9'h000);

    // 4: abort in OUT_LO of a wide op; then start+abort together in IDLE
    drive(1, 1, 0, 0); cyc("t4_c0", 9'h000);
    drive(0, 0, 1, 0); cyc("t4_c1", 9'h100);
    drive(0, 0, 0, 0); cyc("t4_c2", 9'h120);
    drive(0, 0, 0, 1); cyc("t4_c3", 9'h112);
    drive(1, 1, 0, 1); cyc("t4_c4", 9'h000);
    drive(0, 0, 0, 0); cyc("t4_c5", 9'h000);
    cyc("t4_c6", 9'h000);

    // 5: clr asserted mid-wait forces outputs low immediately
    drive(1, 0, 0, 0); cyc("t5_c0", 9'h000);
    drive(0, 0, 0, 0); cyc("t5_c1", 9'h100);
    chk("t5_pre", 16'(outs()), 16'h100);
    #2;
    clr = 1'b0;
    #1;
    chk("t5_clr_outs", 16'(outs()), 16'd0);
    chk("t5_clr_state", 16'(xf.state), 16'(S_IDLE));
    @(posedge clk);
    #1;
    clr = 1'b1;
    drive(1, 0, 0, 0); cyc("t5_r0", 9'h000);
    drive(0, 0, 1, 0); cyc("t5_r1", 9'h100);
    drive(0, 0, 0, 0); cyc("t5_r2", 9'h120);
    cyc("t5_r3", 9'h114);
    cyc("t5_r4", 9'h180);
    cyc("t5_r5", 9'h000);

    // 6: start and alu_ready held high, three back-to-back wide transfers
    done_cnt = 0;
    drive(1, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(9'h000);
      exp_q.push_back(9'h100);
      exp_q.push_back(9'h120);
      exp_q.push_back(9'h112);
      exp_q.push_back(9'h109);
      exp_q.push_back(9'h180);
    end
    run_q("t6_b2b");
    drive(0, 0, 0, 0);
    cyc("t6_end", 9'h000);
    chk("t6_dones", 16'(done_cnt), 16'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
